video_text_render: RTL and testbench
====================================

# video_text_render

Text-mode tile renderer fed by the video timing generator's beam position and syncs. It fetches 16-bit character/attribute words from display memory and 8-bit glyph rows from font memory (both synchronous BRAMs), then emits one 3-bit colour per pixel. Sync and visible strobes are delayed to match, and the outputs drive the board's RGB/sync pins.

## Interface
Parameters (taken from package `v`, not overridable per instance):
- `FONT_HEIGHT`, `v::FONT_HEIGHT` (8): glyph rows; 8 or 16.
- `CHARS_WIDE`, `v::CHARS_WIDE` (80): cells per text row.
- `H_SYNC_POLARITY` / `V_SYNC_POLARITY`, from `v`: active sync levels.

Ports:
- `clk`  in  1  pixel clock.
- `reset`  in  1  synchronous, active-high reset.
- `h_count_i`  in  `hres_t`  horizontal beam position.
- `v_count_i`  in  `vres_t`  vertical beam position.
- `visible_i`  in  1  beam inside the visible area.
- `hsync_i`, `vsync_i`  in  1 each  syncs from the timing generator.
- `disp_addr_o`  out  `disp_addr_t`  display memory read address.
- `disp_data_i`  in  `disp_data_t`  display word, valid 1 cycle after its address.
- `font_addr_o`  out  `font_addr_t`  font memory read address.
- `font_data_i`  in  `font_data_t`  glyph row, valid 1 cycle after its address.
- `rgb_o`  out  `color_t`  pixel colour: [2]=R, [1]=G, [0]=B.
- `hsync_o`, `vsync_o`, `visible_o`  out  1 each  delayed copies of the inputs.

## Operation
- **Display word fields**
  - [7:0] character code.
  - [10:8] foreground colour.
  - [11] blink flag, used only with the configuration macro.
  - [14:12] background colour.
  - [15] ignored.
- **Line base register (`line_base`, DISPADDR_W bits)**
  - Cleared when `h_count_i==0 && v_count_i==0`.
  - Incremented by CHARS_WIDE when `h_count_i==VISIBLE_WIDTH`, `v_count_i < VISIBLE_HEIGHT` and `v_count_i % FONT_HEIGHT == FONT_HEIGHT-1`.
  - No multiplier is used.
- **Address and glyph generation**
  - `disp_addr_o = line_base + h_count_i[..:3]`, computed mod 2^DISPADDR_W.
  - With 640x480 and 8-high glyphs, text rows 52+ alias onto low addresses. This is intended; it is not an error.
  - `font_addr_o = {char, row}`, where `row = v % FONT_HEIGHT` carried from stage 0.
- **Pixel select**
  - `bit = font_data_i[7 - h[2:0]]`, with h[2:0] delayed to align.
  - `rgb_o = bit ? fore : back` while the delayed visible is 1; otherwise 0.
- **Frame counter**
  - 6-bit, reset 0.
  - Increments at `h_count_i==0 && v_count_i==VISIBLE_HEIGHT`.
  - Wraps 63 -> 0.
- Addresses are updated every cycle, including blanking. Memory contents during blanking do not affect `rgb_o`.

## Timing
Pipeline, for an input sampled in cycle T:
- T+1: `disp_addr_o` valid.
- T+2: display data arrives; `font_addr_o` and colours are registered.
- T+3: `font_addr_o` valid.
- T+4: glyph row arrives.
- T+5: `rgb_o` valid.

Alignment:
- `hsync_o`, `vsync_o` and `visible_o` are 5-stage delays of their inputs, aligned with `rgb_o`.
- h[2:0] and visible travel through matching delay registers.

No stalls and no handshake; throughput is 1 pixel per clock.

Reset:
- `rgb_o`=0, `visible_o`=0, `disp_addr_o`=0, `font_addr_o`=0.
- `hsync_o`=~H_SYNC_POLARITY and `vsync_o`=~V_SYNC_POLARITY.
- All delay-line stages are cleared to those same inactive values.
- Asserting reset mid-frame takes effect on the next edge. Output is blank with inactive syncs until valid data re-propagates, 5 cycles after release.
- `line_base` resynchronises at the next (0,0) position.

## Configuration
`TEXT_BLINK_EN`:
- **Defined:** when word bit 11 is 1 and `frame_cnt[5]==1`, the foreground is replaced by the background, so the glyph disappears for 32 of every 64 frames. The blink decision is registered with the colours in stage 2.
- **Undefined:** bit 11 is ignored, the frame counter is not built, and behaviour is identical to blink flag 0.

## Test plan
- **Reset:** assert `reset` for 3 cycles mid-line -> `rgb_o`=0, syncs inactive, `visible_o`=0 until 5 cycles after release.
- **Latency:** single cell at address 0 = 16'h2541 ('A', fore 5, back 2) with a font row 0 of 8'h81; drive (h=0, v=0) at T -> `disp_addr_o`=0 at T+1, `font_addr_o`=0x41*FONT_HEIGHT at T+3, `rgb_o`=5 at T+5, `rgb_o`=2 at T+6..T+11, `rgb_o`=5 at T+12.
- **Row stepping:** at v=8, h=0 -> `disp_addr_o`=80; at v=7 -> 0; at v=479, h=640 -> `line_base` increments; at (0,0) -> `line_base` returns to 0.
- **Address wrap:** at text row 52, h=0 -> `disp_addr_o`=52*80 mod 4096=64.
- **Blanking:** `visible_i`=0 with display data fore=7 -> `rgb_o`=0; hsync/vsync pulses reproduced exactly, delayed 5.
- **Blink (TEXT_BLINK_EN):** word 16'h2F41 over 64 frames -> glyph pixels = 7 for frames 0-31 and = 2 (background) for frames 32-63; the same word without the macro -> glyph pixels always 7.

Source files
------------

// File: rtl/video_text_render_if.sv
// Text-mode geometry/types (package v) and the display/font memory read bus.
package v;
    localparam int unsigned VISIBLE_WIDTH   = 640;
    localparam int unsigned VISIBLE_HEIGHT  = 480;
    localparam int unsigned FONT_HEIGHT     = 8;
    localparam int unsigned CHARS_WIDE      = 80;
    localparam logic        H_SYNC_POLARITY = 1'b0;
    localparam logic        V_SYNC_POLARITY = 1'b0;

    localparam int unsigned HRES_W     = 10;
    localparam int unsigned VRES_W     = 10;
    localparam int unsigned DISPADDR_W = 12;
    localparam int unsigned DISPDATA_W = 16;
    localparam int unsigned FONTROW_W  = $clog2(FONT_HEIGHT);
    localparam int unsigned FONTADDR_W = 8 + FONTROW_W;
    localparam int unsigned FONTDATA_W = 8;
    localparam int unsigned COLOR_W    = 3;

    typedef logic [HRES_W-1:0]     hres_t;
    typedef logic [VRES_W-1:0]     vres_t;
    typedef logic [DISPADDR_W-1:0] disp_addr_t;
    typedef logic [DISPDATA_W-1:0] disp_data_t;
    typedef logic [FONTADDR_W-1:0] font_addr_t;
    typedef logic [FONTDATA_W-1:0] font_data_t;
    typedef logic [COLOR_W-1:0]    color_t;

    // Character/attribute word as stored in display memory
    typedef struct packed {
        logic       spare;
        color_t     back;
        logic       blink;
        color_t     fore;
        logic [7:0] code;
    } disp_word_t;
endpackage

interface video_text_render_if;
    v::disp_addr_t disp_addr_o;
    v::disp_data_t disp_data_i;
    v::font_addr_t font_addr_o;
    v::font_data_t font_data_i;

    modport master (output disp_addr_o, output font_addr_o,
                    input  disp_data_i, input  font_data_i);
    modport slave  (input  disp_addr_o, input  font_addr_o,
                    output disp_data_i, output font_data_i);
endinterface

// File: rtl/video_text_render.sv
// Text-mode tile renderer: beam position -> display word -> glyph row -> pixel colour.
// Optional feature macro: TEXT_BLINK_EN (per-cell blink driven by a frame counter).
module video_text_render
    import v::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  hres_t                       h_count_i,
    input  vres_t                       v_count_i,
    input  logic                        visible_i,
    input  logic                        hsync_i,
    input  logic                        vsync_i,
    video_text_render_if.master         mem,
    output color_t                      rgb_o,
    output logic                        hsync_o,
    output logic                        vsync_o,
    output logic                        visible_o
);
    localparam int unsigned PIPE       = 5;
    localparam int unsigned HLO_STAGES = 4;
    localparam logic [PIPE-1:0] HS_IDLE = {PIPE{~H_SYNC_POLARITY}};
    localparam logic [PIPE-1:0] VS_IDLE = {PIPE{~V_SYNC_POLARITY}};

    disp_addr_t                        line_base_q, line_base_d;
    disp_addr_t                        disp_addr_q, disp_addr_d;
    logic [1:0][FONTROW_W-1:0]         row_q, row_d;
    logic [HLO_STAGES-1:0][2:0]        hlo_q, hlo_d;
    logic [PIPE-1:0]                   vis_q, vis_d;
    logic [PIPE-1:0]                   hs_q, hs_d;
    logic [PIPE-1:0]                   vs_q, vs_d;
    font_addr_t                        font_addr_q, font_addr_d;
    color_t                            fg_q, fg_d, bg_q, bg_d;
    color_t                            fg2_q, fg2_d, bg2_q, bg2_d;
    color_t                            rgb_q, rgb_d;
    disp_word_t                        word;
    disp_addr_t                        base;
    logic                              line_clr;
    logic [2:0]                        sel;
`ifdef TEXT_BLINK_EN
    logic [5:0]                        frame_q, frame_d;
`endif

    // Next-state for line base, address/glyph pipeline, delay lines and pixel mux
    always_comb begin
        word     = disp_word_t'(mem.disp_data_i);
        line_clr = (h_count_i == '0) && (v_count_i == '0);

        line_base_d = line_base_q;
        if (line_clr) begin
            line_base_d = '0;
        end else if ((h_count_i == HRES_W'(VISIBLE_WIDTH)) &&
                     (v_count_i < VRES_W'(VISIBLE_HEIGHT)) &&
                     (&v_count_i[FONTROW_W-1:0])) begin
            line_base_d = line_base_q + DISPADDR_W'(CHARS_WIDE);
        end

        // The first cell of a frame must already see the cleared base
        base        = line_clr ? '0 : line_base_q;
        disp_addr_d = base + DISPADDR_W'(h_count_i[HRES_W-1:3]);

        row_d[0] = v_count_i[FONTROW_W-1:0];
        row_d[1] = row_q[0];
        hlo_d    = {hlo_q[HLO_STAGES-2:0], h_count_i[2:0]};
        vis_d    = {vis_q[PIPE-2:0], visible_i};
        hs_d     = {hs_q[PIPE-2:0], hsync_i};
        vs_d     = {vs_q[PIPE-2:0], vsync_i};

        font_addr_d = {word.code, row_q[1]};
        fg_d        = word.fore;
        bg_d        = word.back;
`ifdef TEXT_BLINK_EN
        if (word.blink && frame_q[5]) begin
            fg_d = word.back;
        end
        frame_d = frame_q;
        if ((h_count_i == '0) && (v_count_i == VRES_W'(VISIBLE_HEIGHT))) begin
            frame_d = frame_q + 6'd1;
        end
`endif
        fg2_d = fg_q;
        bg2_d = bg_q;

        sel   = 3'(3'd7 - hlo_q[HLO_STAGES-1]);
        rgb_d = '0;
        if (vis_q[PIPE-2]) begin
            rgb_d = mem.font_data_i[sel] ? fg2_q : bg2_q;
        end
    end

    // Pipeline registers with synchronous reset to blank/inactive values
    always_ff @(posedge clk) begin
        if (reset) begin
            line_base_q <= '0;
            disp_addr_q <= '0;
            row_q       <= '0;
            hlo_q       <= '0;
            vis_q       <= '0;
            hs_q        <= HS_IDLE;
            vs_q        <= VS_IDLE;
            font_addr_q <= '0;
            fg_q        <= '0;
            bg_q        <= '0;
            fg2_q       <= '0;
            bg2_q       <= '0;
            rgb_q       <= '0;
`ifdef TEXT_BLINK_EN
            frame_q     <= '0;
`endif
        end else begin
            line_base_q <= line_base_d;
            disp_addr_q <= disp_addr_d;
            row_q       <= row_d;
            hlo_q       <= hlo_d;
            vis_q       <= vis_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            font_addr_q <= font_addr_d;
            fg_q        <= fg_d;
            bg_q        <= bg_d;
            fg2_q       <= fg2_d;
            bg2_q       <= bg2_d;
            rgb_q       <= rgb_d;
`ifdef TEXT_BLINK_EN
            frame_q     <= frame_d;
`endif
        end
    end

    // Word bits that do not influence the picture
`ifdef TEXT_BLINK_EN
    logic unused_word;
    assign unused_word = word.spare;
`else
    logic unused_word;
    assign unused_word = ^{word.spare, word.blink};
`endif

    assign mem.disp_addr_o = disp_addr_q;
    assign mem.font_addr_o = font_addr_q;
    assign rgb_o           = rgb_q;
    assign visible_o       = vis_q[PIPE-1];
    assign hsync_o         = hs_q[PIPE-1];
    assign vsync_o         = vs_q[PIPE-1];

endmodule

// File: tb/tb_video_text_render.sv
// Directed bench for video_text_render with behavioural synchronous BRAMs.
module tb_video_text_render;
    import v::*;

    logic   clk = 1'b0;
    logic   reset;
    hres_t  h;
    vres_t  vc;
    logic   vis, hs, vs;
    color_t rgb;
    logic   hso, vso, viso;

    int total = 0;
    int bad   = 0;

    logic [15:0] disp_mem [0:4095];
    logic [7:0]  font_mem [0:2047];
    logic [15:0] hpat, vpat;

    video_text_render_if mem_bus ();

    video_text_render dut (
        .clk       (clk),
        .reset     (reset),
        .h_count_i (h),
        .v_count_i (vc),
        .visible_i (vis),
        .hsync_i   (hs),
        .vsync_i   (vs),
        .mem       (mem_bus),
        .rgb_o     (rgb),
        .hsync_o   (hso),
        .vsync_o   (vso),
        .visible_o (viso)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data one cycle after the address
    always @(posedge clk) begin
        mem_bus.disp_data_i <= disp_mem[mem_bus.disp_addr_o];
        mem_bus.font_data_i <= font_mem[mem_bus.font_addr_o];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int hh, input int vv, input logic vi, input logic hsi, input logic vsi);
        h   = HRES_W'(hh);
        vc  = VRES_W'(vv);
        vis = vi;
        hs  = hsi;
        vs  = vsi;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic blink_on;
        int   exp_rgb;
        int   j;
`ifdef TEXT_BLINK_EN
        blink_on = 1'b1;
`else
        blink_on = 1'b0;
`endif
        for (int i = 0; i < 4096; i++) disp_mem[i] = '0;
        for (int i = 0; i < 2048; i++) font_mem[i] = '0;
        disp_mem[0]      = 16'h2541;
        font_mem[11'h208] = 8'h81;
        hpat = 16'b1110_0001_1111_0011;
        vpat = 16'b1111_1100_0011_1111;

        // Power-on reset state
        reset = 1'b1;
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        tick(); tick(); tick();
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_vis", 32'(viso), 0);
        chk("rst_hs", 32'(hso), 1);
        chk("rst_vs", 32'(vso), 1);
        chk("rst_daddr", 32'(mem_bus.disp_addr_o), 0);
        chk("rst_faddr", 32'(mem_bus.font_addr_o), 0);

        // Fill pipeline with active syncs, then reset mid-line
        reset = 1'b0;
        drive(100, 10, 1'b1, 1'b0, 1'b0);
        tick();
        chk("daddr_h100", 32'(mem_bus.disp_addr_o), 12);
        for (int i = 0; i < 7; i++) tick();
        chk("run_vis", 32'(viso), 1);
        chk("run_hs", 32'(hso), 0);
        chk("run_vs", 32'(vso), 0);
        reset = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick();
            chk("mid_rst_vis", 32'(viso), 0);
            chk("mid_rst_hs", 32'(hso), 1);
            chk("mid_rst_vs", 32'(vso), 1);
            chk("mid_rst_rgb", 32'(rgb), 0);
        end
        reset = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            tick();
            if (n < 5) begin
                chk("refill_vis", 32'(viso), 0);
                chk("refill_hs", 32'(hso), 1);
            end else begin
                chk("refill_vis", 32'(viso), 1);
                chk("refill_hs", 32'(hso), 0);
                chk("refill_vs", 32'(vso), 0);
            end
        end

        // Latency: 'A' fore 5 back 2, glyph row 0 = 8'h81
        for (int i = 0; i < 16; i++) begin
            drive(i, 0, 1'b1, 1'b1, 1'b1);
            tick();
            if (i + 1 == 1) chk("lat_daddr", 32'(mem_bus.disp_addr_o), 0);
            if (i + 1 == 3) chk("lat_faddr", 32'(mem_bus.font_addr_o), 32'h208);
            if (i + 1 >= 5 && i + 1 <= 12) begin
                exp_rgb = (i + 1 == 5 || i + 1 == 12) ? 5 : 2;
                chk("lat_rgb", 32'(rgb), 32'(exp_rgb));
            end
        end

        // Row stepping
        drive(0, 7, 1'b0, 1'b1, 1'b1);   tick(); chk("row_v7", 32'(mem_bus.disp_addr_o), 0);
        drive(640, 7, 1'b0, 1'b1, 1'b1); tick();
        drive(0, 8, 1'b0, 1'b1, 1'b1);   tick(); chk("row_v8", 32'(mem_bus.disp_addr_o), 80);
        drive(16, 8, 1'b0, 1'b1, 1'b1);  tick(); chk("row_v8_h16", 32'(mem_bus.disp_addr_o), 82);

        // Address wrap at text row 52
        for (int r = 1; r < 52; r++) begin
            drive(640, r * 8 + 7, 1'b0, 1'b1, 1'b1);
            tick();
        end
        drive(0, 416, 1'b0, 1'b1, 1'b1);  tick(); chk("wrap_row52", 32'(mem_bus.disp_addr_o), 64);
        drive(16, 416, 1'b0, 1'b1, 1'b1); tick(); chk("wrap_row52_h16", 32'(mem_bus.disp_addr_o), 66);

        // Last visible line steps the base; blanking lines do not
        drive(640, 479, 1'b0, 1'b1, 1'b1); tick();
        drive(0, 480, 1'b0, 1'b1, 1'b1);   tick(); chk("row_v480", 32'(mem_bus.disp_addr_o), 144);
        drive(640, 480, 1'b0, 1'b1, 1'b1); tick();
        drive(0, 481, 1'b0, 1'b1, 1'b1);   tick(); chk("row_v481", 32'(mem_bus.disp_addr_o), 144);
        drive(0, 0, 1'b0, 1'b1, 1'b1);     tick(); chk("row_resync", 32'(mem_bus.disp_addr_o), 0);

        // Blanking and sync reproduction: fore 7, back 0
        disp_mem[0] = 16'h0741;
        for (int k = 0; k < 21; k++) begin
            if (k < 16) drive(k % 8, 0, (k >= 8), hpat[k], vpat[k]);
            else        drive(0, 0, 1'b0, 1'b1, 1'b1);
            tick();
            j = k - 4;
            if (j >= 0 && j < 16) begin
                exp_rgb = (j >= 8 && ((j % 8) == 0 || (j % 8) == 7)) ? 7 : 0;
                chk("blank_rgb", 32'(rgb), 32'(exp_rgb));
                chk("sync_h", 32'(hso), 32'(hpat[j]));
                chk("sync_v", 32'(vso), 32'(vpat[j]));
                chk("sync_vis", 32'(viso), 32'(j >= 8));
            end
        end

        // Blink over 64 frames: fore 7, blink set, back 2
        reset = 1'b1;
        drive(0, 0, 1'b0, 1'b1, 1'b1);
        tick(); tick();
        reset = 1'b0;
        disp_mem[0] = 16'h2F41;
        for (int f = 0; f < 64; f++) begin
            drive(0, 0, 1'b1, 1'b1, 1'b1);
            for (int c = 0; c < 5; c++) tick();
            exp_rgb = (blink_on && f >= 32) ? 2 : 7;
            chk("blink_rgb", 32'(rgb), 32'(exp_rgb));
            drive(0, 480, 1'b0, 1'b1, 1'b1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
